prng_mask_reader: RTL
=====================

Name: prng_mask_reader

Overview:
- Consumer end of the 32-bit PRNG mask stream that feeds the masked (LMDPL) datapath.
- Samples the free-running generator word every cycle and discards post-reset warm-up words.
- Screens each word for health, failing on all-zero words or consecutive repeats.
- Buffers good words in a small show-ahead FIFO and serves them to the masking logic over a valid/ready handshake.
- Raises a sticky error and withholds all masks if the generator appears stuck.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- DISCARD, 1, number of sampled words dropped after reset, counted from the first cycle with rng_valid=1.
- STUCK_LIMIT, 2, consecutive bad words that set err_stuck; range 1..15.

Ports:
- clk, input, 1, clock; all state updates on rising edge.
- rst, input, 1, synchronous active-high reset.
- rng_in, input, 32, PRNG output word; may change every cycle.
- rng_valid, input, 1, rng_in holds a fresh word this cycle; tie high for a free-running PRNG.
- mask_data, output, 32, FIFO head word; only meaningful while mask_valid=1.
- mask_valid, output, 1, FIFO non-empty and no error.
- mask_ready, input, 1, consumer takes mask_data this cycle when mask_valid=1.
- fill_level, output, $clog2(DEPTH)+1, number of stored entries.
- err_stuck, output, 1, sticky generator-failure flag.

Behaviour:
- Reset (rst=1 at an edge), values visible after that edge:
  - FIFO empty; fill_level=0; mask_valid=0; mask_data=0; err_stuck=0.
  - discard counter=DISCARD; bad counter=0; prev_word=0.
  - Reset mid-operation drops all stored words and any in-flight handshake.
- Sample condition: rng_valid=1 and err_stuck=0. No other cycle changes discard, bad or prev state.
- Discard phase: while the discard counter is nonzero, each sample decrements it and is dropped. prev_word and the bad counter are not updated.
- Health check, after the discard phase, on each sample:
  - word is bad if rng_in==0 or rng_in==prev_word; prev_word<=rng_in in both cases.
  - bad word: bad counter increments, and the word is never written.
  - good word: bad counter clears; the word is written if the FIFO is not full, otherwise silently dropped.
- Error:
  - On the edge where the bad counter reaches STUCK_LIMIT, err_stuck<=1 and the FIFO is flushed (fill_level<=0).
  - From the next cycle, mask_valid=0.
  - err_stuck holds until rst, and all sampling stops.
- Write/read timing:
  - A word written at edge N gives mask_valid=1 after edge N (one-cycle latency from sample to availability).
  - A read occurs when mask_valid and mask_ready are both 1; the head advances at that edge.
  - mask_data is the head entry combinationally from registered storage.
  - mask_data is undefined when mask_valid=0; the bench does not check it then.
- Full rule: when fill_level==DEPTH, a write is refused even if a read occurs in the same cycle. This keeps full-path timing simple; the next word is taken the following cycle.
- Simultaneous read and write when not full or empty: both occur and fill_level is unchanged. A word written into an empty FIFO cannot be read in the same cycle.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH; fill_level never exceeds DEPTH.
- mask_ready while mask_valid=0 is ignored.
- mask_data holds while mask_valid=1 and mask_ready=0; it is stable until accepted or until err_stuck flushes the FIFO.

Test Plan:
- Warm-up, DISCARD=1, DEPTH=4, STUCK_LIMIT=2, mask_ready=0:
  - Stimulus: rst for 2 cycles; rng_valid=1; rng_in sequence 0x00000000, 0x11111111, 0x22222222, 0x33333333, 0x44444444, 0x55555555.
  - Required: the first 0 is discarded, not counted bad; fill_level reaches 4; head=0x11111111; 0x55555555 dropped; err_stuck=0.
- Drain with ready high:
  - Stimulus: from the full state, mask_ready=1 for 4 cycles, rng_valid=0.
  - Required: outputs 0x11111111, 0x22222222, 0x33333333, 0x44444444 in order; then mask_valid=0 and fill_level=0.
- Simultaneous read and write at fill_level=2:
  - Stimulus: mask_ready=1, rng_valid=1 with fresh distinct words.
  - Required: fill_level stays 2; ordering is preserved.
- Full with read:
  - Stimulus: fill_level=4, mask_ready=1, new good word.
  - Required: the word is dropped; fill_level=3 after the edge.
- Stuck detection:
  - Stimulus: words 0xA5A5A5A5, 0xA5A5A5A5, 0xA5A5A5A5.
  - Required: the second is bad (count 1) and the third is bad (count 2). err_stuck=1 after the third edge; fill_level=0 and mask_valid=0 next cycle; it stays set under further good words until rst.
- Zero screen:
  - Stimulus: 0x12345678, 0x00000000, 0x9ABCDEF0.
  - Required: the zero is not stored; the bad count clears on 0x9ABCDEF0; FIFO holds 0x12345678 then 0x9ABCDEF0; err_stuck=0.
- Reset mid-operation:
  - Stimulus: assert rst while fill_level=3 and mask_valid=1.
  - Required: after the edge, fill_level=0, mask_valid=0, err_stuck=0, and the discard phase restarts.

Source files
------------

// File: rtl/prng_mask_reader_if.sv
// Mask-stream bundle: PRNG sample input, masked-datapath handshake and status.
interface prng_mask_reader_if #(
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned FW = $clog2(DEPTH) + 1;

    logic [31:0]   rng_in;
    logic          rng_valid;
    logic [31:0]   mask_data;
    logic          mask_valid;
    logic          mask_ready;
    logic [FW-1:0] fill_level;
    logic          err_stuck;

    modport master (
        output rng_in, rng_valid, mask_ready,
        input  mask_data, mask_valid, fill_level, err_stuck
    );

    modport slave (
        input  rng_in, rng_valid, mask_ready,
        output mask_data, mask_valid, fill_level, err_stuck
    );
endinterface

// File: rtl/prng_mask_reader.sv
// PRNG mask consumer: warm-up discard, health screen (zero/repeat), show-ahead FIFO,
// sticky stuck-generator error that flushes and withholds all masks.
module prng_mask_reader #(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned DISCARD     = 1,
    parameter int unsigned STUCK_LIMIT = 2
) (
    input  logic               clk,
    input  logic               rst,
    prng_mask_reader_if.slave  bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned FW = AW + 1;
    localparam int unsigned DW = ($clog2(DISCARD + 1) > 0) ? $clog2(DISCARD + 1) : 1;
    localparam int unsigned BW = 4;

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [FW-1:0] count;
    logic [DW-1:0] disc_cnt;
    logic [BW-1:0] bad_cnt;
    logic [31:0]   prev_word;
    logic          err_stuck;

    logic sample_c;
    logic in_discard_c;
    logic health_c;
    logic bad_word_c;
    logic trip_c;
    logic full_c;
    logic wr_c;
    logic rd_c;
    logic valid_c;

    // Sampling and FIFO control decisions for this cycle
    always_comb begin
        sample_c     = bus.rng_valid && !err_stuck;
        in_discard_c = (disc_cnt != '0);
        health_c     = sample_c && !in_discard_c;
        bad_word_c   = (bus.rng_in == 32'h0) || (bus.rng_in == prev_word);
        trip_c       = health_c && bad_word_c && (bad_cnt == BW'(STUCK_LIMIT - 1));
        full_c       = (count == FW'(DEPTH));
        // A full FIFO refuses writes even when a read frees a slot this cycle
        wr_c         = health_c && !bad_word_c && !full_c;
        valid_c      = (count != '0) && !err_stuck;
        rd_c         = valid_c && bus.mask_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            disc_cnt  <= DW'(DISCARD);
            bad_cnt   <= '0;
            prev_word <= '0;
            err_stuck <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (sample_c) begin
                if (in_discard_c) begin
                    disc_cnt <= disc_cnt - DW'(1);
                end else begin
                    prev_word <= bus.rng_in;
                    bad_cnt   <= bad_word_c ? bad_cnt + BW'(1) : '0;
                end
            end

            // Stuck trip flushes the FIFO and overrides any same-cycle read
            if (trip_c) begin
                err_stuck <= 1'b1;
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                count     <= '0;
            end else begin
                if (wr_c) begin
                    mem[wr_ptr] <= bus.rng_in;
                    wr_ptr      <= wr_ptr + AW'(1);
                end
                if (rd_c) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                if (wr_c && !rd_c) begin
                    count <= count + FW'(1);
                end else if (rd_c && !wr_c) begin
                    count <= count - FW'(1);
                end
            end
        end
    end

    assign bus.mask_data  = mem[rd_ptr];
    assign bus.mask_valid = valid_c;
    assign bus.fill_level = count;
    assign bus.err_stuck  = err_stuck;

endmodule
